// File: rtl/tile_renderer.sv
// ---------------------------------------------------------------------------
// tile_renderer
//
// Text/tile-mode pixel generator. Each 8x8 1bpp tile is drawn 2x scaled
// (16x16 screen pixels), giving a 40x30 cell grid on a 640x480 raster.
// While one cell is on screen, the next cell (the one to its right, or
// column 0 of the next visible line) is fetched into a prefetch buffer.
// The buffer is copied into the display registers at the first pixel of
// each cell.
//
// Each attribute cell n occupies two bytes:
//   byte 2n   = tile index
//   byte 2n+1 = foreground palette index [7:4], background index [3:0]
//
// Ports
//   clk                           system clock (100 MHz)
//   reset_n                       asynchronous active-low reset
//   pixel_strobe                  1-clk pulse per pixel (every 4 clks)
//   hpos / vpos                   raster position of the current strobe
//   tile_memory_read_*            pattern memory read port (addr = idx*8+line)
//   attribute_memory_read_*       attribute memory read port
//   color_memory_read_*           16-entry RGB332 palette read port
//   pixel_color                   registered RGB332 pixel, 0 outside active area
//   pixel_valid                   pixel_strobe delayed by one clock
//   fetch_overrun                 sticky flag: trigger arrived while fetching
//
// All memories return data one clock after their read enable.
// ---------------------------------------------------------------------------
module tile_renderer #(
    parameter int COLS     = 40,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pixel_strobe,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    output logic        tile_memory_read_enable,
    output logic [10:0] tile_memory_read_addr,
    input  logic [7:0]  tile_memory_read_data,
    output logic        attribute_memory_read_enable,
    output logic [11:0] attribute_memory_read_addr,
    input  logic [7:0]  attribute_memory_read_data,
    output logic        color_memory_read_enable,
    output logic [3:0]  color_memory_read_addr,
    input  logic [7:0]  color_memory_read_data,
    output logic [7:0]  pixel_color,
    output logic        pixel_valid,
    output logic        fetch_overrun
);

    // Raster constants narrowed to the position width.
    localparam logic [9:0] H_ACTIVE_W  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_CELL = 10'(H_ACTIVE - 16);
    localparam logic [9:0] V_ACTIVE_W  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_LINE = 10'(V_TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        A0,
        A1,
        TR,
        FG,
        BG,
        DONE
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    // Trigger decode and target cell computation
    logic        cell_start;
    logic        trigger;
    logic        fetch_go;
    logic        swap;
    logic        active;
    logic [5:0]  target_col;
    logic [9:0]  vnext;
    logic [4:0]  target_row;
    logic [2:0]  target_line;
    logic [10:0] cell_index;
    logic [11:0] attr_base;

    // Fetch working registers
    logic [11:0] cell_addr_q;
    logic [2:0]  line_q;
    logic [7:0]  tile_idx_q;
    logic [3:0]  fg_idx_q;
    logic [3:0]  bg_idx_q;
    logic [7:0]  pattern_q;
    logic [7:0]  fg_color_q;

    // Prefetch buffer and display registers
    logic [7:0]  buf_pattern;
    logic [7:0]  buf_fg;
    logic [7:0]  buf_bg;
    logic [7:0]  disp_pattern;
    logic [7:0]  disp_fg;
    logic [7:0]  disp_bg;

    // Pixel selection
    logic [7:0]  sel_pattern;
    logic [7:0]  sel_fg;
    logic [7:0]  sel_bg;
    logic [2:0]  bit_index;
    logic        pixel_bit;

    // Work out which cell the next fetch targets. The last cell of a line
    // prefetches column 0 of the following line, wrapping at the frame end.
    // The row*COLS product is a shift-add since COLS is fixed at 40.
    always_comb begin
        cell_start = pixel_strobe && (hpos[3:0] == 4'd0);
        trigger    = cell_start && (hpos <= H_LAST_CELL);

        if (hpos < H_LAST_CELL) begin
            target_col = hpos[9:4] + 6'd1;
            vnext      = vpos;
        end else begin
            target_col = 6'd0;
            vnext      = (vpos == V_LAST_LINE) ? 10'd0 : vpos + 10'd1;
        end

        target_row  = vnext[8:4];
        target_line = vnext[3:1];
        cell_index  = ({6'd0, target_row} << 5) + ({6'd0, target_row} << 3)
                    + {5'd0, target_col};
        attr_base   = {cell_index, 1'b0};

        fetch_go = trigger && (state == IDLE) && (vnext < V_ACTIVE_W);

        active = (hpos < H_ACTIVE_W) && (vpos < V_ACTIVE_W);
        swap   = cell_start && active;
    end

    // Fetch FSM state register; reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and read port decode. Each fetch state drives exactly one
    // read enable; the data it returns is captured in the following state.
    always_comb begin
        state_next                   = state;
        attribute_memory_read_enable = 1'b0;
        attribute_memory_read_addr   = 12'd0;
        tile_memory_read_enable      = 1'b0;
        tile_memory_read_addr        = 11'd0;
        color_memory_read_enable     = 1'b0;
        color_memory_read_addr       = 4'd0;

        case (state)
            IDLE: begin
                if (fetch_go) begin
                    state_next = A0;
                end
            end
            A0: begin
                attribute_memory_read_enable = 1'b1;
                attribute_memory_read_addr   = cell_addr_q;
                state_next                   = A1;
            end
            A1: begin
                attribute_memory_read_enable = 1'b1;
                attribute_memory_read_addr   = {cell_addr_q[11:1], 1'b1};
                state_next                   = TR;
            end
            TR: begin
                tile_memory_read_enable = 1'b1;
                tile_memory_read_addr   = {tile_idx_q, line_q};
                state_next              = FG;
            end
            FG: begin
                color_memory_read_enable = 1'b1;
                color_memory_read_addr   = fg_idx_q;
                state_next               = BG;
            end
            BG: begin
                color_memory_read_enable = 1'b1;
                color_memory_read_addr   = bg_idx_q;
                state_next               = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fetch datapath: latch the target on trigger, then capture each read
    // result one state after its request. The prefetch buffer is only
    // written in DONE, so a partially fetched cell is never displayed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_addr_q <= 12'd0;
            line_q      <= 3'd0;
            tile_idx_q  <= 8'd0;
            fg_idx_q    <= 4'd0;
            bg_idx_q    <= 4'd0;
            pattern_q   <= 8'd0;
            fg_color_q  <= 8'd0;
            buf_pattern <= 8'd0;
            buf_fg      <= 8'd0;
            buf_bg      <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_go) begin
                        cell_addr_q <= attr_base;
                        line_q      <= target_line;
                    end
                end
                A1: begin
                    tile_idx_q <= attribute_memory_read_data;
                end
                TR: begin
                    fg_idx_q <= attribute_memory_read_data[7:4];
                    bg_idx_q <= attribute_memory_read_data[3:0];
                end
                FG: begin
                    pattern_q <= tile_memory_read_data;
                end
                BG: begin
                    fg_color_q <= color_memory_read_data;
                end
                DONE: begin
                    buf_pattern <= pattern_q;
                    buf_fg      <= fg_color_q;
                    buf_bg      <= color_memory_read_data;
                end
                default: begin
                end
            endcase
        end
    end

    // A trigger that lands while a fetch is still running is dropped; the
    // flag stays set until reset so software can see it happened.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_overrun <= 1'b0;
        end else if (trigger && (state != IDLE)) begin
            fetch_overrun <= 1'b1;
        end
    end

    // On the first pixel of a cell the display registers take the buffer,
    // and that same pixel must already use the new cell, so the selection
    // bypasses the display registers when swapping.
    always_comb begin
        sel_pattern = swap ? buf_pattern : disp_pattern;
        sel_fg      = swap ? buf_fg      : disp_fg;
        sel_bg      = swap ? buf_bg      : disp_bg;
        bit_index   = 3'd7 - hpos[3:1];
        pixel_bit   = sel_pattern[bit_index];
    end

    // Display registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_pattern <= 8'd0;
            disp_fg      <= 8'd0;
            disp_bg      <= 8'd0;
        end else if (swap) begin
            disp_pattern <= buf_pattern;
            disp_fg      <= buf_fg;
            disp_bg      <= buf_bg;
        end
    end

    // Pixel output: updated only on a strobe and held between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_color <= 8'd0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= pixel_strobe;
            if (pixel_strobe) begin
                pixel_color <= active ? (pixel_bit ? sel_fg : sel_bg) : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// ---------------------------------------------------------------------------
// tb_tile_renderer
//
// Directed bench for tile_renderer. Behavioural memories with one-clock
// read latency surround the DUT; strobes are driven on falling edges and
// outputs are sampled on the falling edge after the strobe.
// ---------------------------------------------------------------------------
module tb_tile_renderer;

    logic        clk;
    logic        reset_n;
    logic        pixel_strobe;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        tile_en;
    logic [10:0] tile_addr;
    logic [7:0]  tile_data;
    logic        attr_en;
    logic [11:0] attr_addr;
    logic [7:0]  attr_data;
    logic        color_en;
    logic [3:0]  color_addr;
    logic [7:0]  color_data;
    logic [7:0]  pixel_color;
    logic        pixel_valid;
    logic        fetch_overrun;

    logic [7:0]  tile_mem  [0:2047];
    logic [7:0]  attr_mem  [0:4095];
    logic [7:0]  color_mem [0:15];
    logic [7:0]  t1_exp    [0:15];
    logic [2:0]  t2_en_exp [0:6];

    int total_checks;
    int bad_checks;
    int en_count;
    int snap;

    tile_renderer dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .pixel_strobe                 (pixel_strobe),
        .hpos                         (hpos),
        .vpos                         (vpos),
        .tile_memory_read_enable      (tile_en),
        .tile_memory_read_addr        (tile_addr),
        .tile_memory_read_data        (tile_data),
        .attribute_memory_read_enable (attr_en),
        .attribute_memory_read_addr   (attr_addr),
        .attribute_memory_read_data   (attr_data),
        .color_memory_read_enable     (color_en),
        .color_memory_read_addr       (color_addr),
        .color_memory_read_data       (color_data),
        .pixel_color                  (pixel_color),
        .pixel_valid                  (pixel_valid),
        .fetch_overrun                (fetch_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with one clock of read latency
    always @(posedge clk) begin
        if (tile_en)  tile_data  <= tile_mem[tile_addr];
        if (attr_en)  attr_data  <= attr_mem[attr_addr];
        if (color_en) color_data <= color_mem[color_addr];
    end

    // Count every clock on which any read enable is high
    always @(posedge clk) begin
        if (reset_n && (tile_en || attr_en || color_en)) en_count <= en_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge with the
    // strobe removed and the registered pixel outputs available.
    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
        pixel_strobe = 1'b1;
        hpos         = h;
        vpos         = v;
        @(negedge clk);
        pixel_strobe = 1'b0;
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        en_count     = 0;
        tile_data    = 8'd0;
        attr_data    = 8'd0;
        color_data   = 8'd0;
        pixel_strobe = 1'b0;
        hpos         = 10'd0;
        vpos         = 10'd0;
        reset_n      = 1'b1;

        for (int i = 0; i < 2048; i++) tile_mem[i] = 8'h00;
        for (int i = 0; i < 4096; i++) attr_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++)   color_mem[i] = 8'h00;
        attr_mem[0]       = 8'h41;
        attr_mem[1]       = 8'h2F;
        tile_mem[11'h208] = 8'hA5;
        color_mem[2]      = 8'hE0;
        color_mem[15]     = 8'h03;
        attr_mem[164]     = 8'h12;
        attr_mem[165]     = 8'h7C;
        tile_mem[146]     = 8'h3C;
        color_mem[7]      = 8'h1C;
        color_mem[12]     = 8'hC3;
        color_mem[0]      = 8'h55;

        t1_exp = '{8'hE0, 8'hE0, 8'h03, 8'h03, 8'hE0, 8'hE0, 8'h03, 8'h03,
                   8'h03, 8'h03, 8'hE0, 8'hE0, 8'h03, 8'h03, 8'hE0, 8'hE0};
        t2_en_exp = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000};

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_color", pixel_color, 8'h00);
        checkOutput("rst_valid", pixel_valid, 1'b0);
        checkOutput("rst_overrun", fetch_overrun, 1'b0);
        checkOutput("rst_enables", {attr_en, tile_en, color_en}, 3'b000);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: prefetch row 0 col 0 during vertical blank, then draw it
        $display("[TB] test 1: first cell of frame");
        applyStimulus(10'd624, 10'd524);
        checkOutput("t1_blank_color", pixel_color, 8'h00);
        checkOutput("t1_a0_enable", attr_en, 1'b1);
        checkOutput("t1_a0_addr", attr_addr, 12'd0);
        repeat (12) @(negedge clk);
        for (int h = 0; h < 16; h++) begin
            applyStimulus(10'(h), 10'd0);
            checkOutput($sformatf("t1_px%0d", h), pixel_color, t1_exp[h]);
            if (h == 0) begin
                checkOutput("t1_valid_hi", pixel_valid, 1'b1);
                @(negedge clk);
                checkOutput("t1_valid_lo", pixel_valid, 1'b0);
                checkOutput("t1_hold", pixel_color, 8'hE0);
                repeat (2) @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
        end
        repeat (10) @(negedge clk);

        // Test 2: fetch sequence for row 2 col 2 line 2
        $display("[TB] test 2: fetch read sequence");
        applyStimulus(10'd16, 10'd37);
        for (int s = 0; s < 7; s++) begin
            checkOutput($sformatf("t2_en%0d", s), {attr_en, tile_en, color_en}, t2_en_exp[s]);
            case (s)
                0: checkOutput("t2_attr0", attr_addr, 12'd164);
                1: checkOutput("t2_attr1", attr_addr, 12'd165);
                2: checkOutput("t2_tile", tile_addr, 11'd146);
                3: checkOutput("t2_fg", color_addr, 4'h7);
                4: checkOutput("t2_bg", color_addr, 4'hC);
                default: ;
            endcase
            @(negedge clk);
        end
        applyStimulus(10'd32, 10'd37);
        checkOutput("t2_swap_px", pixel_color, 8'hC3);
        repeat (10) @(negedge clk);

        // Test 4: outside the active area, display registers untouched
        $display("[TB] test 4: horizontal blank");
        applyStimulus(10'd640, 10'd10);
        checkOutput("t4_valid640", pixel_valid, 1'b1);
        checkOutput("t4_color640", pixel_color, 8'h00);
        repeat (3) @(negedge clk);
        applyStimulus(10'd700, 10'd10);
        checkOutput("t4_valid700", pixel_valid, 1'b1);
        checkOutput("t4_color700", pixel_color, 8'h00);
        repeat (3) @(negedge clk);
        applyStimulus(10'd38, 10'd37);
        checkOutput("t4_disp_fg", pixel_color, 8'h1C);
        repeat (3) @(negedge clk);
        applyStimulus(10'd34, 10'd37);
        checkOutput("t4_disp_bg", pixel_color, 8'hC3);
        repeat (3) @(negedge clk);

        // Test 3: no fetch past the last visible line, wrap at frame end
        $display("[TB] test 3: vertical limits");
        snap = en_count;
        applyStimulus(10'd624, 10'd479);
        repeat (10) @(negedge clk);
        checkOutput("t3_skip", 32'(en_count - snap), 32'd0);
        applyStimulus(10'd624, 10'd524);
        checkOutput("t3_wrap_en", {attr_en, tile_en, color_en}, 3'b100);
        checkOutput("t3_wrap_addr", attr_addr, 12'd0);
        checkOutput("t3_wrap_color", pixel_color, 8'h00);
        repeat (10) @(negedge clk);

        // Test 5: second trigger two clocks after the first
        $display("[TB] test 5: overrun");
        checkOutput("t5_ovr_before", fetch_overrun, 1'b0);
        snap = en_count;
        applyStimulus(10'd0, 10'd100);
        @(negedge clk);
        applyStimulus(10'd16, 10'd100);
        repeat (15) @(negedge clk);
        checkOutput("t5_ovr_set", fetch_overrun, 1'b1);
        checkOutput("t5_one_fetch", 32'(en_count - snap), 32'd5);
        repeat (50) @(negedge clk);
        checkOutput("t5_ovr_held", fetch_overrun, 1'b1);

        // Test 6: asynchronous reset in the middle of a fetch
        $display("[TB] test 6: reset during tile read");
        applyStimulus(10'd48, 10'd50);
        checkOutput("t6_px", pixel_color, 8'h55);
        repeat (2) @(negedge clk);
        checkOutput("t6_in_tr", {attr_en, tile_en, color_en}, 3'b010);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t6_enables", {attr_en, tile_en, color_en}, 3'b000);
        checkOutput("t6_color", pixel_color, 8'h00);
        checkOutput("t6_valid", pixel_valid, 1'b0);
        checkOutput("t6_overrun", fetch_overrun, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        snap = en_count;
        repeat (4) @(negedge clk);
        checkOutput("t6_idle", 32'(en_count - snap), 32'd0);
        applyStimulus(10'd64, 10'd50);
        checkOutput("t6_refetch_en", attr_en, 1'b1);
        checkOutput("t6_refetch_addr", attr_addr, 12'd250);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
